shift_ctrl_serializer: RTL

- Sequencing controller for the analyzer's parallel-load/serial-out shift register. It accepts a captured sample word over a valid/ready handshake and strobes the register's load. It then paces one shift per bit period and frames the serial stream UART-style (start bit, BITS data bits LSB-first, stop bit).
- Sits between the sample capture logic and the serial TX pin mux.
- Drives the load and shift-enable strobes of an enable-capable shift register instance, plus the line-select for the pin mux.

---
 rtl/shift_ctrl_serializer.sv | 114 +++++++++++
 1 files changed

// File: rtl/shift_ctrl_serializer.sv
// shift_ctrl_serializer
// Sequences a parallel-load/serial-out shift register into a UART-style frame:
// start bit, BITS data bits LSB-first, stop bit, each lasting i_div+1 cycles.
// Optional build macro: SERCTRL_B2B_EN accepts the next word in the last stop
// cycle so frames run back-to-back with no idle cycle between them.
module shift_ctrl_serializer #(
    parameter int BITS  = 8,
    parameter int DIV_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [DIV_W-1:0] i_div,
    input  logic             i_valid,
    output logic             o_ready,
    output logic             o_load,
    output logic             o_shift,
    output logic [1:0]       o_line_sel,
    output logic             o_busy,
    output logic             o_done
);
    localparam int             BCW      = (BITS > 1) ? $clog2(BITS) : 1;
    localparam logic [BCW-1:0] LAST_BIT = BCW'(BITS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [DIV_W-1:0] r_div_cnt, w_div_cnt_nxt;
    logic [DIV_W-1:0] r_div_lat, w_div_lat_nxt;
    logic [BCW-1:0]   r_bit_cnt, w_bit_cnt_nxt;
    logic             w_period_end;

    // A bit period ends on the cycle the divider has counted down to zero
    assign w_period_end = (r_div_cnt == '0);
    assign o_busy       = (r_state != S_IDLE);

    // State and counter registers; reset discards any frame in flight
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_div_cnt <= '0;
            r_div_lat <= '0;
            r_bit_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_div_cnt <= w_div_cnt_nxt;
            r_div_lat <= w_div_lat_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
        end
    end

    // Next-state, bit pacing and strobe generation
    always_comb begin
        w_state_nxt   = r_state;
        w_div_cnt_nxt = r_div_cnt;
        w_div_lat_nxt = r_div_lat;
        w_bit_cnt_nxt = r_bit_cnt;
        o_ready       = 1'b0;
        o_shift       = 1'b0;
        o_done        = 1'b0;
        o_line_sel    = 2'd0;

        // Divider free-runs through every framed state, reloading at period end
        if (r_state != S_IDLE)
            w_div_cnt_nxt = w_period_end ? r_div_lat : r_div_cnt - 1'b1;

        case (r_state)
            S_IDLE: begin
                o_ready = 1'b1;
            end
            S_START: begin
                o_line_sel = 2'd1;
                if (w_period_end) begin
                    w_state_nxt   = S_DATA;
                    w_bit_cnt_nxt = '0;
                end
            end
            S_DATA: begin
                o_line_sel = 2'd2;
                // Shift after every data bit, the last one included, so the
                // register is drained by the time the stop bit starts
                o_shift    = w_period_end;
                if (w_period_end) begin
                    if (r_bit_cnt == LAST_BIT)
                        w_state_nxt = S_STOP;
                    else
                        w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                end
            end
            S_STOP: begin
                o_line_sel = 2'd3;
                o_done     = w_period_end;
                if (w_period_end)
                    w_state_nxt = S_IDLE;
`ifdef SERCTRL_B2B_EN
                o_ready    = w_period_end;
`endif
            end
            default: ;
        endcase

        // Handshake: capture the word and divider, open a new frame
        o_load = i_valid & o_ready;
        if (o_load) begin
            w_state_nxt   = S_START;
            w_div_lat_nxt = i_div;
            w_div_cnt_nxt = i_div;
        end
    end
endmodule
